// File: rtl/req_gnt_pkg.sv
// Shared types and default sizing for the req/gnt responder and its round-robin selector.
package req_gnt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } rg_state_e;

  localparam int RG_N_REQ    = 4;
  localparam int RG_LAT_W    = 4;
  localparam int RG_MAX_WAIT = 64;

endpackage

// File: rtl/req_gnt_responder_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after rr_ptr, wrapping.
module rr_pick
  import req_gnt_pkg::*;
#(
  parameter int N_REQ = RG_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand_s;

  // Walk from the farthest offset down so the closest request to rr_ptr wins.
  always_comb begin
    valid  = 1'b0;
    idx    = {IDX_W{1'b0}};
    cand_s = {IDX_W{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_s = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      idx    = req[cand_s] ? cand_s : idx;
      valid  = valid | req[cand_s];
    end
  end

endmodule

// File: rtl/req_gnt_responder.sv
// Responder end of the req/gnt handshake: round-robin arbitration, programmable grant
// latency, single-cycle one-hot grant pulse and sticky per-requester wait-timeout flags.
module req_gnt_responder
  import req_gnt_pkg::*;
#(
  parameter int N_REQ    = RG_N_REQ,
  parameter int LAT_W    = RG_LAT_W,
  parameter int MAX_WAIT = RG_MAX_WAIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [LAT_W-1:0]           latency,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic [N_REQ-1:0]           timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WC_W  = $clog2(MAX_WAIT + 1);

  rg_state_e        state_r, state_s;
  logic [LAT_W-1:0] lat_r, lat_s;
  logic [IDX_W-1:0] rr_ptr_r, rr_ptr_s;
  logic [IDX_W-1:0] gid_r, gid_s;
  logic [N_REQ-1:0] gnt_r, gnt_s;
  logic             busy_r, busy_s;
  logic [N_REQ-1:0] terr_r, terr_s;
  logic [WC_W-1:0]  wcnt_r [N_REQ];
  logic [WC_W-1:0]  wcnt_s [N_REQ];
  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .valid  (pick_valid_s),
    .idx    (pick_idx_s)
  );

  // Handshake FSM next-state, latency countdown and registered-output next values.
  always_comb begin
    state_s  = state_r;
    lat_s    = lat_r;
    gid_s    = gid_r;
    rr_ptr_s = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s = WAIT;
          gid_s   = pick_idx_s;
          lat_s   = latency;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        // A dropped request aborts even when the countdown has just expired.
        if (!req[gid_r]) begin
          state_s = IDLE;
        end else if (lat_r == {LAT_W{1'b0}}) begin
          state_s = GRANT;
        end else begin
          lat_s = lat_r - LAT_W'(1'b1);
        end
      end
      GRANT: begin
        state_s = RELEASE;
        if (gid_r == IDX_W'(N_REQ - 1)) begin
          rr_ptr_s = {IDX_W{1'b0}};
        end else begin
          rr_ptr_s = gid_r + IDX_W'(1'b1);
        end
      end
      RELEASE: begin
        if (!req[gid_r]) begin
          state_s = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    gnt_s  = (state_s == GRANT) ? ({{(N_REQ-1){1'b0}}, 1'b1} << gid_s) : {N_REQ{1'b0}};
    busy_s = (state_s != IDLE);
  end

  // Saturating per-requester wait counters and sticky timeout flags.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      if (!req[i] || gnt_r[i]) begin
        wcnt_s[i] = {WC_W{1'b0}};
      end else if (wcnt_r[i] == WC_W'(MAX_WAIT)) begin
        wcnt_s[i] = wcnt_r[i];
      end else begin
        wcnt_s[i] = wcnt_r[i] + WC_W'(1'b1);
      end
      terr_s[i] = terr_r[i] | (wcnt_s[i] == WC_W'(MAX_WAIT));
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      lat_r    <= {LAT_W{1'b0}};
      rr_ptr_r <= {IDX_W{1'b0}};
      gid_r    <= {IDX_W{1'b0}};
      gnt_r    <= {N_REQ{1'b0}};
      busy_r   <= 1'b0;
      terr_r   <= {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
        wcnt_r[i] <= {WC_W{1'b0}};
      end
    end else begin
      state_r  <= state_s;
      lat_r    <= lat_s;
      rr_ptr_r <= rr_ptr_s;
      gid_r    <= gid_s;
      gnt_r    <= gnt_s;
      busy_r   <= busy_s;
      terr_r   <= terr_s;
      for (int i = 0; i < N_REQ; i++) begin
        wcnt_r[i] <= wcnt_s[i];
      end
    end
  end

  assign gnt         = gnt_r;
  assign grant_id    = gid_r;
  assign busy        = busy_r;
  assign timeout_err = terr_r;

endmodule
